button_event: RTL and testbench

- Sits directly downstream of the debouncer in the clock design.
- Takes the clean, debounced button level and produces discrete, single-cycle user events for the time-setting logic:
  - press
  - release
  - short click
  - long-press
  - auto-repeat while held (fast-advance of hours/minutes)
- Contains its own millisecond prescaler. Timing restarts at every press, so event timing is deterministic relative to the press.

---
 rtl/button_event.sv | 127 ++++++++++++
 tb/tb_button_event.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle press/release/click/long-press/auto-repeat events.
// Timing is measured in millisecond ticks from an internal prescaler that restarts on every press.
module button_event #(
    parameter int CLK_PER_MS = 100000,
    parameter int LONG_MS    = 1000,
    parameter int REPEAT_MS  = 200
) (
    input  logic ck,
    input  logic rst_n,
    input  logic button_deb,
    output logic press,
    output logic release_evt,
    output logic click,
    output logic long_press,
    output logic repeat_evt,
    output logic long_active
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int HW = (LONG_MS    > 1) ? $clog2(LONG_MS)    : 1;
    localparam int RW = (REPEAT_MS  > 1) ? $clog2(REPEAT_MS)  : 1;

    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_PER_MS - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_MS - 1);
    localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_MS - 1);

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    state_t        state, state_nxt;
    logic          btn_q;
    logic [PW-1:0] presc, presc_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic [RW-1:0] rep, rep_nxt;
    logic          rise, fall, tick;
    logic          press_nxt, release_nxt, click_nxt;
    logic          long_press_nxt, repeat_nxt, long_active_nxt;

    // btn_q resets high so a button held through reset never looks like a fresh press
    assign rise = button_deb & ~btn_q;
    assign fall = ~button_deb & btn_q;
    assign tick = (presc == PRE_MAX);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            btn_q       <= 1'b1;
            presc       <= '0;
            hold        <= '0;
            rep         <= '0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            click       <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
            long_active <= 1'b0;
        end else begin
            state       <= state_nxt;
            btn_q       <= button_deb;
            presc       <= presc_nxt;
            hold        <= hold_nxt;
            rep         <= rep_nxt;
            press       <= press_nxt;
            release_evt <= release_nxt;
            click       <= click_nxt;
            long_press  <= long_press_nxt;
            repeat_evt  <= repeat_nxt;
            long_active <= long_active_nxt;
        end
    end

    // A fall always takes priority over a threshold tick landing in the same cycle
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        rep_nxt   = rep;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = HELD;
                    hold_nxt  = '0;
                    rep_nxt   = '0;
                end
            end
            HELD: begin
                if (fall) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (hold == HOLD_MAX) begin
                        state_nxt = LONG;
                        rep_nxt   = '0;
                    end else begin
                        hold_nxt = hold + HW'(1);
                    end
                end
            end
            LONG: begin
                if (fall) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (rep == REP_MAX) begin
                        rep_nxt = '0;
                    end else begin
                        rep_nxt = rep + RW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (rise || state_nxt == IDLE || tick) begin
            presc_nxt = '0;
        end else begin
            presc_nxt = presc + PW'(1);
        end
    end

    always_comb begin
        press_nxt       = (state == IDLE) && rise;
        release_nxt     = (state != IDLE) && fall;
        click_nxt       = (state == HELD) && fall;
        long_press_nxt  = (state == HELD) && !fall && tick && (hold == HOLD_MAX);
        repeat_nxt      = long_press_nxt ||
                          ((state == LONG) && !fall && tick && (rep == REP_MAX));
        long_active_nxt = (state_nxt == LONG);
    end

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: directed scenarios plus random presses, checked every cycle
// against a press-relative timing model and per-scenario event counts.
module tb_button_event;

    localparam int C  = 10;
    localparam int L  = 5;
    localparam int R  = 2;
    localparam int LC = L * C;
    localparam int RC = R * C;

    logic ck = 1'b0;
    logic rst_n;
    logic b, b2;
    logic press, release_evt, click, long_press, repeat_evt, long_active;
    logic press2, release2, click2, long_press2, repeat2, long_active2;

    int n_asserts = 0;
    int n_fails   = 0;

    button_event #(.CLK_PER_MS(C), .LONG_MS(L), .REPEAT_MS(R)) dut (
        .ck(ck), .rst_n(rst_n), .button_deb(b),
        .press(press), .release_evt(release_evt), .click(click),
        .long_press(long_press), .repeat_evt(repeat_evt), .long_active(long_active)
    );

    button_event dut_def (
        .ck(ck), .rst_n(rst_n), .button_deb(b2),
        .press(press2), .release_evt(release2), .click(click2),
        .long_press(long_press2), .repeat_evt(repeat2), .long_active(long_active2)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: every event is a function of cycles elapsed since the press pulse
    logic m_prev, m_held;
    int   m_n, m_p, m_d;
    logic m_rise, m_fall;
    logic e_press, e_rel, e_click, e_long, e_rep, e_la;

    assign m_rise = b & ~m_prev;
    assign m_fall = ~b & m_prev;
    assign m_d    = (m_n + 1) - m_p;

    always @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            m_prev  <= 1'b1;
            m_held  <= 1'b0;
            m_n     <= 0;
            m_p     <= 0;
            e_press <= 1'b0;
            e_rel   <= 1'b0;
            e_click <= 1'b0;
            e_long  <= 1'b0;
            e_rep   <= 1'b0;
            e_la    <= 1'b0;
        end else begin
            m_n     <= m_n + 1;
            m_prev  <= b;
            e_press <= !m_held && m_rise;
            e_rel   <= m_held && m_fall;
            e_click <= m_held && m_fall && (m_d <= LC);
            e_long  <= m_held && !m_fall && (m_d == LC);
            e_rep   <= m_held && !m_fall && (m_d >= LC) && (((m_d - LC) % RC) == 0);
            e_la    <= m_held && !m_fall && (m_d >= LC);
            if (!m_held && m_rise) begin
                m_held <= 1'b1;
                m_p    <= m_n + 1;
            end else if (m_held && m_fall) begin
                m_held <= 1'b0;
            end
        end
    end

    always @(negedge ck) begin
        chk("cyc.press",       press,       e_press);
        chk("cyc.release",     release_evt, e_rel);
        chk("cyc.click",       click,       e_click);
        chk("cyc.long_press",  long_press,  e_long);
        chk("cyc.repeat",      repeat_evt,  e_rep);
        chk("cyc.long_active", long_active, e_la);
    end

    // Event counters (active cycles of each output) for both instances
    int cnt1 [6] = '{default: 0};
    int cnt2 [6] = '{default: 0};
    int base1 [6] = '{default: 0};
    int base2 [6] = '{default: 0};
    string nm [6] = '{"press", "release", "click", "long_press", "repeat", "long_active"};

    always @(negedge ck) begin
        if (press)        cnt1[0] <= cnt1[0] + 1;
        if (release_evt)  cnt1[1] <= cnt1[1] + 1;
        if (click)        cnt1[2] <= cnt1[2] + 1;
        if (long_press)   cnt1[3] <= cnt1[3] + 1;
        if (repeat_evt)   cnt1[4] <= cnt1[4] + 1;
        if (long_active)  cnt1[5] <= cnt1[5] + 1;
        if (press2)       cnt2[0] <= cnt2[0] + 1;
        if (release2)     cnt2[1] <= cnt2[1] + 1;
        if (click2)       cnt2[2] <= cnt2[2] + 1;
        if (long_press2)  cnt2[3] <= cnt2[3] + 1;
        if (repeat2)      cnt2[4] <= cnt2[4] + 1;
        if (long_active2) cnt2[5] <= cnt2[5] + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic hold(input int hi, input int lo);
        b = 1'b1;
        step(hi);
        b = 1'b0;
        step(lo);
    endtask

    // A negative expectation skips that counter
    task automatic expect_counts(input string tag, input bit second,
                                 input int p, input int r, input int c,
                                 input int l, input int rp, input int la);
        int e [6];
        e = '{p, r, c, l, rp, la};
        for (int i = 0; i < 6; i++) begin
            if (e[i] >= 0) begin
                if (second) chk($sformatf("%s.%s", tag, nm[i]), cnt2[i] - base2[i], e[i]);
                else        chk($sformatf("%s.%s", tag, nm[i]), cnt1[i] - base1[i], e[i]);
            end
        end
        base1 = cnt1;
        base2 = cnt2;
    endtask

    initial begin
        rst_n = 1'b0;
        b     = 1'b0;
        b2    = 1'b0;
        step(3);
        chk("reset.press",       press,       0);
        chk("reset.release",     release_evt, 0);
        chk("reset.click",       click,       0);
        chk("reset.long_press",  long_press,  0);
        chk("reset.repeat",      repeat_evt,  0);
        chk("reset.long_active", long_active, 0);
        rst_n = 1'b1;
        step(5);
        base1 = cnt1;
        base2 = cnt2;

        hold(20, 10);
        expect_counts("short", 0, 1, 1, 1, 0, 0, 0);

        hold(100, 10);
        expect_counts("long", 0, 1, 1, 0, 1, 3, 50);

        hold(50, 10);
        expect_counts("fall_on_tick", 0, 1, 1, 1, 0, 0, 0);

        hold(51, 10);
        expect_counts("fall_after_tick", 0, 1, 1, 0, 1, 1, 1);

        b = 1'b1;
        step(60);
        rst_n = 1'b0;
        #1;
        chk("async_rst.press",       press,       0);
        chk("async_rst.repeat",      repeat_evt,  0);
        chk("async_rst.long_active", long_active, 0);
        chk("async_rst.long_press",  long_press,  0);
        step(5);
        rst_n = 1'b1;
        step(10);
        b = 1'b0;
        step(10);
        expect_counts("held_thru_rst", 0, 1, 0, 0, 1, 1, -1);
        hold(20, 10);
        expect_counts("after_rst", 0, 1, 1, 1, 0, 0, 0);

        hold(20, 3);
        hold(20, 10);
        expect_counts("double", 0, 2, 2, 2, 0, 0, 0);
        hold(20, 3);
        hold(70, 10);
        expect_counts("restart", 0, 2, 2, 1, 1, 1, 20);

        for (int i = 0; i < 12; i++) begin
            hold($urandom_range(130, 1), $urandom_range(25, 1));
        end
        base1 = cnt1;
        base2 = cnt2;

        b2 = 1'b1;
        step(1000);
        b2 = 1'b0;
        step(5);
        expect_counts("default_short", 1, 1, 1, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
